entry_scan_buf: RTL

Register-backed entry store that sits directly upstream of the index/enable read mux. It holds DEPTH entries of WID bits, each with a valid bit, and exposes the whole array to the mux as its packed data input. On request, a scan engine walks all valid entries in index order, drives the mux index and read enable, captures each returned word, and presents it on a valid/ready output stream.

---
 rtl/entry_scan_buf_if.sv | 44 ++++
 rtl/entry_scan_buf.sv | 117 +++++++++++
 2 files changed

// File: rtl/entry_scan_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : entry_scan_buf_if
// Brief    : Write, scan-control, mux and output-stream bundle for entry_scan_buf.
// Revision : 1.0
// ============================================================================
interface entry_scan_buf_if #(
    parameter int WIDTH = 5,
    parameter int WID   = 32,
    parameter int DEPTH = 1 << WIDTH
);
    logic                      wr_en_i;
    logic [WIDTH-1:0]          wr_index_i;
    logic [WID-1:0]            wr_data_i;
    logic                      clr_i;
    logic [DEPTH-1:0][WID-1:0] table_o;
    logic [DEPTH-1:0]          entry_valid_o;
    logic                      scan_start_i;
    logic                      busy_o;
    logic                      done_o;
    logic [WIDTH-1:0]          mux_index_o;
    logic                      mux_read_en_o;
    logic [WID-1:0]            mux_data_i;
    logic                      mux_ready_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [WID-1:0]            out_data_o;
    logic [WIDTH-1:0]          out_index_o;

    modport slave (
        input  wr_en_i, wr_index_i, wr_data_i, clr_i, scan_start_i,
               mux_data_i, mux_ready_i, out_ready_i,
        output table_o, entry_valid_o, busy_o, done_o, mux_index_o,
               mux_read_en_o, out_valid_o, out_data_o, out_index_o
    );

    modport master (
        output wr_en_i, wr_index_i, wr_data_i, clr_i, scan_start_i,
               mux_data_i, mux_ready_i, out_ready_i,
        input  table_o, entry_valid_o, busy_o, done_o, mux_index_o,
               mux_read_en_o, out_valid_o, out_data_o, out_index_o
    );
endinterface
`default_nettype wire

// File: rtl/entry_scan_buf.sv
`default_nettype none
// ============================================================================
// Module   : entry_scan_buf
// Brief    : Register-backed entry store with a scan engine that reads valid
//            entries through an external index/enable mux onto a stream.
// Revision : 1.0
// ============================================================================
module entry_scan_buf #(
    parameter int WIDTH = 5,
    parameter int WID   = 32,
    parameter int DEPTH = 1 << WIDTH
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    entry_scan_buf_if.slave bus
);
    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                    r_state;
    logic [DEPTH-1:0][WID-1:0] r_table;
    logic [DEPTH-1:0]          r_valid;
    logic [WIDTH-1:0]          r_ptr;
    logic                      r_out_valid;
    logic [WID-1:0]            r_out_data;
    logic [WIDTH-1:0]          r_out_index;
    logic                      w_hit;

    assign w_hit = (r_state == ST_SCAN) && r_valid[r_ptr];

    // Write is ordered after clear so a same-cycle write keeps its valid bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_table <= '0;
            r_valid <= '0;
        end else begin
            if (bus.clr_i) begin
                r_valid <= '0;
            end
            if (bus.wr_en_i) begin
                r_table[bus.wr_index_i] <= bus.wr_data_i;
                r_valid[bus.wr_index_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else if (bus.clr_i) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.scan_start_i) begin
                        r_state <= ST_SCAN;
                        r_ptr   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!r_valid[r_ptr]) begin
                        if (r_ptr == c_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end else if (bus.mux_ready_i) begin
                        r_out_data  <= bus.mux_data_i;
                        r_out_index <= r_ptr;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready_i) begin
                        r_out_valid <= 1'b0;
                        if (r_ptr == c_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.table_o       = r_table;
    assign bus.entry_valid_o = r_valid;
    assign bus.busy_o        = (r_state != ST_IDLE);
    assign bus.done_o        = (r_state == ST_DONE);
    assign bus.mux_index_o   = w_hit ? r_ptr : '0;
    assign bus.mux_read_en_o = w_hit;
    assign bus.out_valid_o   = r_out_valid;
    assign bus.out_data_o    = r_out_data;
    assign bus.out_index_o   = r_out_index;
endmodule
`default_nettype wire
